// File: rtl/bus_arb_if.sv
// Refill-bus bundle between the two cache refill ports, the arbiter and the memory side.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface bus_arb_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BLK_W  = 59
) ();

  logic [BLK_W-1:0]  b_addr_i;
  logic              b_rd_i;
  logic [LINE_W-1:0] b_rdata_i;
  logic              b_dv_i;

  logic [BLK_W-1:0]  b_addr_d;
  logic              b_rd_d;
  logic [LINE_W-1:0] b_rdata_d;
  logic              b_dv_d;

  logic [BLK_W-1:0]  m_addr;
  logic              m_rd;
  logic              m_ack;
  logic [LINE_W-1:0] m_rdata;
  logic              m_dv;

  logic              busy;
  logic              gnt_d;

  modport master (
    input  b_addr_i, b_rd_i, b_addr_d, b_rd_d, m_ack, m_rdata, m_dv,
    output b_rdata_i, b_dv_i, b_rdata_d, b_dv_d, m_addr, m_rd, busy, gnt_d
  );

  modport slave (
    output b_addr_i, b_rd_i, b_addr_d, b_rd_d, m_ack, m_rdata, m_dv,
    input  b_rdata_i, b_dv_i, b_rdata_d, b_dv_d, m_addr, m_rd, busy, gnt_d
  );

endinterface

// File: rtl/bus_arb.sv
// Round-robin arbiter/sequencer sharing one line-fill bus between the imem and dmem refill ports.
// One refill in flight at a time: grant, request handshake, wait for the line, route it back.
module bus_arb #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BLK_W  = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_arb_if.master    io_bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e             r_state, w_state_nxt;
  logic               r_gnt_d, w_gnt_d_nxt;
  logic               r_live, w_live_nxt;
  logic [BLK_W-1:0]   r_addr, w_addr_nxt;
  logic [LINE_W-1:0]  r_rdata_i, w_rdata_i_nxt;
  logic [LINE_W-1:0]  r_rdata_d, w_rdata_d_nxt;
  logic               r_mask_i, r_mask_d;

  logic               w_req_i, w_req_d;
  logic               w_owner_rd;
  logic               w_capture;
  logic               w_dv_i, w_dv_d;

  // A requester that just received its line is ignored for one idle cycle.
  assign w_req_i    = io_bus.b_rd_i & ~r_mask_i;
  assign w_req_d    = io_bus.b_rd_d & ~r_mask_d;
  assign w_owner_rd = r_gnt_d ? io_bus.b_rd_d : io_bus.b_rd_i;

  assign w_dv_i = (r_state == StResp) & r_live & ~r_gnt_d;
  assign w_dv_d = (r_state == StResp) & r_live & r_gnt_d;

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_d_nxt   = r_gnt_d;
    w_live_nxt    = r_live;
    w_addr_nxt    = r_addr;
    w_rdata_i_nxt = r_rdata_i;
    w_rdata_d_nxt = r_rdata_d;
    w_capture     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_req_i | w_req_d) begin
          w_state_nxt = StReq;
          // On a tie, the requester that was not the last owner wins.
          w_gnt_d_nxt = w_req_d & (~w_req_i | ~r_gnt_d);
          w_addr_nxt  = w_gnt_d_nxt ? io_bus.b_addr_d : io_bus.b_addr_i;
          w_live_nxt  = 1'b1;
        end
      end
      StReq: begin
        w_live_nxt = r_live & w_owner_rd;
        if (io_bus.m_ack) begin
          if (io_bus.m_dv) begin
            w_state_nxt = StResp;
            w_capture   = 1'b1;
          end else begin
            w_state_nxt = StWait;
          end
        end
      end
      StWait: begin
        w_live_nxt = r_live & w_owner_rd;
        if (io_bus.m_dv) begin
          w_state_nxt = StResp;
          w_capture   = 1'b1;
        end
      end
      StResp: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    // A withdrawn transaction still completes on the bus but its line is dropped.
    if (w_capture && w_live_nxt) begin
      if (r_gnt_d) begin
        w_rdata_d_nxt = io_bus.m_rdata;
      end else begin
        w_rdata_i_nxt = io_bus.m_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_gnt_d   <= 1'b0;
      r_live    <= 1'b0;
      r_addr    <= '0;
      r_rdata_i <= '0;
      r_rdata_d <= '0;
      r_mask_i  <= 1'b0;
      r_mask_d  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt_d   <= w_gnt_d_nxt;
      r_live    <= w_live_nxt;
      r_addr    <= w_addr_nxt;
      r_rdata_i <= w_rdata_i_nxt;
      r_rdata_d <= w_rdata_d_nxt;
      r_mask_i  <= w_dv_i;
      r_mask_d  <= w_dv_d;
    end
  end

  assign io_bus.m_rd      = (r_state == StReq);
  assign io_bus.m_addr    = r_addr;
  assign io_bus.b_dv_i    = w_dv_i;
  assign io_bus.b_dv_d    = w_dv_d;
  assign io_bus.b_rdata_i = r_rdata_i;
  assign io_bus.b_rdata_d = r_rdata_d;
  assign io_bus.busy      = (r_state != StIdle);
  assign io_bus.gnt_d     = r_gnt_d;

endmodule

// File: tb/tb_bus_arb.sv
// Self-checking bench for bus_arb: directed scenarios plus a randomized run against a
// transaction-level model of the round-robin refill rules.
module tb_bus_arb;

  localparam int unsigned LW = 256;
  localparam int unsigned BW = 59;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arb_if #(.LINE_W(LW), .BLK_W(BW)) bus ();

  bus_arb #(.LINE_W(LW), .BLK_W(BW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [LW-1:0] exp_rdata_i = '0;
  logic [LW-1:0] exp_rdata_d = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.b_addr_i = '0; bus.b_rd_i = 1'b0;
    bus.b_addr_d = '0; bus.b_rd_d = 1'b0;
    bus.m_ack = 1'b0; bus.m_dv = 1'b0; bus.m_rdata = '0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_rdata_i = '0;
    exp_rdata_d = '0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_addr();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[BW-1:0];
  endfunction

  task automatic wait_rd(output bit to);
    to = 1'b1;
    for (int w = 0; w < 20; w++) begin
      if (bus.m_rd === 1'b1) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  // Memory-side responder; returns in the cycle the line should be routed back.
  task automatic mem_serve(input int ack_dly, input int dv_dly, input logic [LW-1:0] line,
                           output bit to, output logic [BW-1:0] a, output bit unstable);
    unstable = 1'b0;
    a = '0;
    wait_rd(to);
    if (to) return;
    a = bus.m_addr;
    for (int s = 0; s < ack_dly; s++) begin
      if (bus.m_rd !== 1'b1 || bus.m_addr !== a) unstable = 1'b1;
      tick();
    end
    if (bus.m_rd !== 1'b1 || bus.m_addr !== a) unstable = 1'b1;
    bus.m_ack = 1'b1;
    if (dv_dly < 0) begin
      bus.m_dv = 1'b1; bus.m_rdata = line;
      tick();
      bus.m_ack = 1'b0; bus.m_dv = 1'b0;
      return;
    end
    tick();
    bus.m_ack = 1'b0;
    for (int s = 0; s < dv_dly; s++) tick();
    bus.m_dv = 1'b1; bus.m_rdata = line;
    tick();
    bus.m_dv = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.m_rd !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_rd_busy: got %b%b, want 00", bus.m_rd, bus.busy);
    end
    n_cmp++;
    if (bus.m_addr !== '0) begin
      n_err++; $display("FAIL reset_m_addr: got %h, want 0", bus.m_addr);
    end
    n_cmp++;
    if (bus.b_dv_i !== 1'b0 || bus.b_dv_d !== 1'b0 || bus.gnt_d !== 1'b0) begin
      n_err++; $display("FAIL reset_dv_gnt: got %b%b%b, want 000", bus.b_dv_i, bus.b_dv_d,
                        bus.gnt_d);
    end
    n_cmp++;
    if (bus.b_rdata_i !== '0 || bus.b_rdata_d !== '0) begin
      n_err++; $display("FAIL reset_rdata: got %h / %h, want 0", bus.b_rdata_i, bus.b_rdata_d);
    end
  endtask

  task automatic test_single_dmem();
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};
    do_reset();
    bus.b_addr_d = 59'h123;
    bus.b_rd_d = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.m_ack = (c == 1);
      bus.m_dv = (c == 4);
      bus.m_rdata = (c == 4) ? a5 : '0;
      n_cmp++;
      if (bus.m_rd !== (c == 1) || bus.b_dv_d !== (c == 5) || bus.b_dv_i !== 1'b0) begin
        n_err++; $display("FAIL single_seq c%0d: got rd=%b dvd=%b dvi=%b, want %b%b0", c,
                          bus.m_rd, bus.b_dv_d, bus.b_dv_i, c == 1, c == 5);
      end
      if (c == 1) begin
        n_cmp++;
        if (bus.m_addr !== 59'h123) begin
          n_err++; $display("FAIL single_addr: got %h, want 123", bus.m_addr);
        end
      end
      if (c == 5) begin
        exp_rdata_d = a5;
        bus.b_rd_d = 1'b0;
        n_cmp++;
        if (bus.b_rdata_d !== exp_rdata_d) begin
          n_err++; $display("FAIL single_rdata: got %h, want %h", bus.b_rdata_d, exp_rdata_d);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (bus.busy !== 1'b0) begin
          n_err++; $display("FAIL single_busy: got %b, want 0", bus.busy);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [LW-1:0] line;
    logic [BW-1:0] a;
    bit to, un, exp_d;
    do_reset();
    bus.b_addr_i = 59'h10; bus.b_addr_d = 59'h20;
    bus.b_rd_i = 1'b1; bus.b_rd_d = 1'b1;
    exp_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      line = rand_line();
      mem_serve(0, 1, line, to, a, un);
      n_cmp++;
      if (to || a !== (exp_d ? 59'h20 : 59'h10)) begin
        n_err++; $display("FAIL rr_addr k%0d: got %h (to=%b), want %h", k, a, to,
                          exp_d ? 59'h20 : 59'h10);
      end
      if (exp_d) exp_rdata_d = line; else exp_rdata_i = line;
      n_cmp++;
      if (bus.b_dv_d !== exp_d || bus.b_dv_i !== !exp_d) begin
        n_err++; $display("FAIL rr_route k%0d: got dvi=%b dvd=%b, want dvd=%b", k, bus.b_dv_i,
                          bus.b_dv_d, exp_d);
      end
      n_cmp++;
      if (bus.b_rdata_i !== exp_rdata_i || bus.b_rdata_d !== exp_rdata_d) begin
        n_err++; $display("FAIL rr_rdata k%0d: got %h / %h, want %h / %h", k, bus.b_rdata_i,
                          bus.b_rdata_d, exp_rdata_i, exp_rdata_d);
      end
      exp_d = !exp_d;
    end
    bus.b_rd_i = 1'b0; bus.b_rd_d = 1'b0;
    tick(); tick();
  endtask

  task automatic test_ack_stall();
    logic [LW-1:0] line;
    logic [BW-1:0] a, want;
    bit to, un;
    int extra;
    want = rand_addr();
    line = rand_line();
    bus.b_addr_i = want; bus.b_rd_i = 1'b1;
    mem_serve(6, 2, line, to, a, un);
    n_cmp++;
    if (to || un || a !== want) begin
      n_err++; $display("FAIL stall_hold: got addr %h to=%b unstable=%b, want %h", a, to, un, want);
    end
    exp_rdata_i = line;
    n_cmp++;
    if (bus.b_dv_i !== 1'b1 || bus.b_rdata_i !== exp_rdata_i) begin
      n_err++; $display("FAIL stall_dv: got %b %h, want 1 %h", bus.b_dv_i, bus.b_rdata_i, line);
    end
    bus.b_rd_i = 1'b0;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.m_rd === 1'b1 || bus.b_dv_i === 1'b1) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_err++; $display("FAIL stall_single: got %0d extra cycles active, want 0", extra);
    end
  endtask

  task automatic test_withdraw();
    bit to;
    bus.b_addr_i = rand_addr(); bus.b_rd_i = 1'b1;
    wait_rd(to);
    n_cmp++;
    if (to) begin
      n_err++; $display("FAIL withdraw_grant: got no m_rd, want m_rd");
      bus.b_rd_i = 1'b0;
      return;
    end
    bus.m_ack = 1'b1;
    tick();
    bus.m_ack = 1'b0;
    bus.b_rd_i = 1'b0;
    tick();
    tick();
    bus.m_dv = 1'b1; bus.m_rdata = rand_line();
    tick();
    bus.m_dv = 1'b0;
    n_cmp++;
    if (bus.b_dv_i !== 1'b0 || bus.busy !== 1'b1 || bus.b_rdata_i !== exp_rdata_i) begin
      n_err++; $display("FAIL withdraw_drop: got dv=%b busy=%b %h, want 0 1 %h", bus.b_dv_i,
                        bus.busy, bus.b_rdata_i, exp_rdata_i);
    end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.b_dv_i !== 1'b0) begin
      n_err++; $display("FAIL withdraw_idle: got busy=%b dv=%b, want 0 0", bus.busy, bus.b_dv_i);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int bad;
    bus.b_addr_d = rand_addr(); bus.b_rd_d = 1'b1;
    wait_rd(to);
    bus.m_ack = 1'b1;
    tick();
    bus.m_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (to || bus.busy !== 1'b0 || bus.m_rd !== 1'b0 || bus.m_addr !== '0) begin
      n_err++; $display("FAIL rstmid_ctl: got busy=%b rd=%b addr=%h to=%b, want 0 0 0 0",
                        bus.busy, bus.m_rd, bus.m_addr, to);
    end
    n_cmp++;
    if (bus.b_rdata_i !== '0 || bus.b_rdata_d !== '0 || bus.gnt_d !== 1'b0) begin
      n_err++; $display("FAIL rstmid_data: got %h / %h gnt=%b, want 0", bus.b_rdata_i,
                        bus.b_rdata_d, bus.gnt_d);
    end
    exp_rdata_i = '0; exp_rdata_d = '0;
    bus.b_rd_d = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.m_dv = 1'b1; bus.m_rdata = rand_line();
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      bus.m_dv = 1'b0;
      if (bus.b_dv_d !== 1'b0 || bus.b_dv_i !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0 || bus.b_rdata_d !== exp_rdata_d) begin
      n_err++; $display("FAIL rstmid_late_dv: got %0d active cycles, rdata %h, want 0", bad,
                        bus.b_rdata_d);
    end
  endtask

  task automatic test_held_request();
    logic [LW-1:0] line;
    logic [BW-1:0] a, want;
    bit to, un;
    int bad;
    line = rand_line();
    bus.b_addr_d = rand_addr(); bus.b_rd_d = 1'b1;
    mem_serve(1, 0, line, to, a, un);
    exp_rdata_d = line;
    n_cmp++;
    if (to || bus.b_dv_d !== 1'b1 || bus.b_rdata_d !== exp_rdata_d) begin
      n_err++; $display("FAIL held_first: got dv=%b %h, want 1 %h", bus.b_dv_d, bus.b_rdata_d,
                        line);
    end
    tick();
    bad = (bus.m_rd !== 1'b0 || bus.busy !== 1'b0) ? 1 : 0;
    bus.b_rd_d = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.m_rd !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL held_no_dup: got %0d busy cycles, want 0", bad);
    end
    // Request that stays up past the mask cycle is served again.
    want = rand_addr();
    line = rand_line();
    bus.b_addr_d = want; bus.b_rd_d = 1'b1;
    mem_serve(0, 0, line, to, a, un);
    exp_rdata_d = line;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL held_mask: got busy=%b, want 0", bus.busy);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.m_rd !== 1'b1 || bus.m_addr !== want) begin
      n_err++; $display("FAIL held_refetch: got rd=%b %h, want 1 %h", bus.m_rd, bus.m_addr, want);
    end
    line = rand_line();
    mem_serve(0, 0, line, to, a, un);
    exp_rdata_d = line;
    n_cmp++;
    if (to || bus.b_dv_d !== 1'b1 || bus.b_rdata_d !== exp_rdata_d) begin
      n_err++; $display("FAIL held_second: got dv=%b %h, want 1 %h", bus.b_dv_d, bus.b_rdata_d,
                        line);
    end
    bus.b_rd_d = 1'b0;
    tick(); tick();
  endtask

  // Randomized traffic: two requesters and a memory with random latencies. The model tracks
  // who asked, who should win each grant (round robin), and which line each owner must get.
  task automatic test_random();
    bit ri, rd, pi, pd, last_d, own_d, stop;
    logic [BW-1:0] ai, ad, want;
    logic [LW-1:0] line;
    int idle_i, idle_d, iss_i, iss_d, done_i, done_d, mst, cnt, dvd, cyc;
    do_reset();
    ri = 0; rd = 0; pi = 0; pd = 0; last_d = 0; own_d = 0;
    ai = '0; ad = '0; line = '0;
    idle_i = 3; idle_d = 3; iss_i = 0; iss_d = 0; done_i = 0; done_d = 0;
    mst = 0; cnt = 0; dvd = 0; cyc = 0;
    while (cyc < 4000) begin
      stop = (cyc >= 1500);
      if (stop && !ri && !rd && mst == 0) break;
      if (mst == 3) begin
        n_cmp++;
        if (bus.b_dv_d !== own_d || bus.b_dv_i !== !own_d) begin
          n_err++; $display("FAIL rand_route cyc%0d: got dvi=%b dvd=%b, want dvd=%b", cyc,
                            bus.b_dv_i, bus.b_dv_d, own_d);
        end
        n_cmp++;
        if ((own_d ? bus.b_rdata_d : bus.b_rdata_i) !== line) begin
          n_err++; $display("FAIL rand_rdata cyc%0d: got %h, want %h", cyc,
                            own_d ? bus.b_rdata_d : bus.b_rdata_i, line);
        end
        if (own_d) begin rd = 0; idle_d = 0; done_d++; end
        else begin ri = 0; idle_i = 0; done_i++; end
        mst = 0;
      end else begin
        n_cmp++;
        if (bus.b_dv_i !== 1'b0 || bus.b_dv_d !== 1'b0) begin
          n_err++; $display("FAIL rand_spurious_dv cyc%0d: got %b%b, want 00", cyc, bus.b_dv_i,
                            bus.b_dv_d);
        end
      end
      if (mst == 0 && bus.m_rd === 1'b1) begin
        own_d = (pi && pd) ? !last_d : pd;
        want = own_d ? ad : ai;
        n_cmp++;
        if (!(pi || pd) || bus.m_addr !== want) begin
          n_err++; $display("FAIL rand_grant cyc%0d: got %h, want %h (req %b%b)", cyc,
                            bus.m_addr, want, pi, pd);
        end
        last_d = own_d;
        mst = 1; cnt = $urandom_range(0, 3); dvd = $urandom_range(0, 3);
        line = rand_line();
      end else if (mst == 1) begin
        n_cmp++;
        if (bus.m_rd !== 1'b1 || bus.m_addr !== (own_d ? ad : ai)) begin
          n_err++; $display("FAIL rand_stable cyc%0d: got rd=%b %h, want 1 %h", cyc, bus.m_rd,
                            bus.m_addr, own_d ? ad : ai);
        end
      end
      if (!ri) begin
        idle_i++;
        if (!stop && idle_i >= 3 && $urandom_range(0, 3) == 0) begin
          ri = 1; ai = rand_addr(); iss_i++;
        end
      end
      if (!rd) begin
        idle_d++;
        if (!stop && idle_d >= 3 && $urandom_range(0, 3) == 0) begin
          rd = 1; ad = rand_addr(); iss_d++;
        end
      end
      bus.b_rd_i = ri; bus.b_addr_i = ai;
      bus.b_rd_d = rd; bus.b_addr_d = ad;
      bus.m_ack = 1'b0; bus.m_dv = 1'b0;
      if (mst == 1) begin
        if (cnt == 0) begin
          bus.m_ack = 1'b1;
          if (dvd == 0 && $urandom_range(0, 1) == 1) begin
            bus.m_dv = 1'b1; bus.m_rdata = line; mst = 3;
          end else begin
            mst = 2;
          end
        end else begin
          cnt--;
        end
      end else if (mst == 2) begin
        if (dvd == 0) begin
          bus.m_dv = 1'b1; bus.m_rdata = line; mst = 3;
        end else begin
          dvd--;
        end
      end else if (mst == 0 && $urandom_range(0, 7) == 0) begin
        // Stray line-valid while nothing is outstanding must be ignored.
        bus.m_dv = 1'b1; bus.m_rdata = rand_line();
      end
      pi = ri; pd = rd;
      tick();
      cyc++;
    end
    n_cmp++;
    if (iss_i !== done_i || iss_d !== done_d || ri || rd || mst != 0) begin
      n_err++; $display("FAIL rand_drain: got done %0d/%0d, want %0d/%0d (mst %0d)", done_i,
                        done_d, iss_i, iss_d, mst);
    end
    n_cmp++;
    if (iss_i == 0 || iss_d == 0) begin
      n_err++; $display("FAIL rand_activity: got issued %0d/%0d, want both nonzero", iss_i, iss_d);
    end
    bus.b_rd_i = 1'b0; bus.b_rd_d = 1'b0;
  endtask

  initial begin
    clr_inputs();
    test_reset();
    test_single_dmem();
    test_round_robin();
    test_ack_stall();
    test_withdraw();
    test_reset_mid();
    test_held_request();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
Name: bus_arb

Overview:
Two-requester arbiter and sequencer that shares the single external line-fill bus between the instruction cache refill port (_i) and the data cache refill port (_d).
Sits between the core's cache refill ports and the memory/interconnect side.
Grants one refill at a time using round-robin, launches it with a valid/ack handshake, waits for the returned line, and routes the data-valid pulse back to the owning cache.

Parameters:
LINE_W, 256, cache line width in bits (matches DMEM_LINE/IMEM_LINE).
BLK_W, 59, line-block address width (64 - log2(LINE_W/8)).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
b_addr_i  in  BLK_W  imem refill block address.
b_rd_i  in  1  imem refill request (level, held until b_dv_i or withdrawn).
b_rdata_i  out  LINE_W  line returned to imem.
b_dv_i  out  1  one-cycle data-valid pulse to imem.
b_addr_d  in  BLK_W  dmem refill block address.
b_rd_d  in  1  dmem refill request (level).
b_rdata_d  out  LINE_W  line returned to dmem.
b_dv_d  out  1  one-cycle data-valid pulse to dmem.
m_addr  out  BLK_W  block address to memory side.
m_rd  out  1  memory read request valid.
m_ack  in  1  memory accepted request (m_rd && m_ack = transfer).
m_rdata  in  LINE_W  line from memory.
m_dv  in  1  one-cycle line-valid pulse from memory.
busy  out  1  a transaction is in flight (state != S_IDLE).
gnt_d  out  1  current or last owner is dmem (0 = imem).

Behaviour:
- Reset (async, rst_n=0):
  - state=S_IDLE; m_rd=0; m_addr=0; b_dv_i=0; b_dv_d=0; b_rdata_i=0; b_rdata_d=0; busy=0.
  - gnt_d=0, so dmem wins the first tie.
  - Takes effect immediately, including mid-transaction; any in-flight memory response after reset release is ignored (m_dv in S_IDLE is dropped).
- State register, 2 bits: S_IDLE, S_REQ, S_WAIT, S_RESP.
- S_IDLE:
  - If b_rd_i or b_rd_d is set, grant and go to S_REQ.
  - If exactly one requests, grant it.
  - If both request, grant the one that is not the last owner: gnt_d=1 -> imem, gnt_d=0 -> dmem.
  - On grant, register the owner into gnt_d, latch the owner's address into m_addr, and latch a live flag = 1.
- S_REQ:
  - m_rd=1 and m_addr is stable.
  - On m_ack, go to S_WAIT, with m_rd low from the next cycle.
  - m_ack and m_dv in the same cycle: go directly to S_RESP and capture data.
- S_WAIT: on m_dv, capture m_rdata into the owner's b_rdata register and go to S_RESP.
- S_RESP:
  - b_dv_<owner>=1 for exactly this cycle, only if live=1.
  - Next state is S_IDLE.
  - The arbiter re-arbitrates in S_IDLE, so two back-to-back grants are separated by at least one idle cycle.
- Minimum latency: request at cycle 0 -> m_rd at cycle 1 -> with m_ack at 1 and m_dv at 2, b_dv at cycle 3.
- Withdrawal:
  - If the owner's b_rd drops in S_REQ/S_WAIT, clear live.
  - The transaction still completes with memory (no abort on the bus), and the line is discarded: no b_dv, b_rdata unchanged.
  - A new request from the same requester waits for S_IDLE.
- Requester address changes after grant are ignored; m_addr holds the latched value until the next grant.
- Non-owner request: stays pending (no drop, no stall signalling); it is served next by the round-robin rule.
- b_rdata_x registers hold their value between transfers.
- A requester keeping b_rd high for one cycle after its b_dv (cache FSM transitioning) must not cause a duplicate fetch.
  - Rule: a requester whose b_dv pulsed in the previous cycle is masked for one cycle in S_IDLE.
- m_dv outside S_REQ/S_WAIT is ignored.
- busy = (state != S_IDLE).

Test Plan:
- Single dmem refill: b_rd_d=1, b_addr_d=0x123 at cycle 0; m_ack at 1; m_dv at 4 with m_rdata=0xA5..A5 -> m_addr=0x123 with m_rd high cycle 1 only; b_dv_d pulses at cycle 5 with b_rdata_d=0xA5..A5; b_dv_i stays 0.
- Simultaneous requests after reset: b_rd_i=b_rd_d=1 held, imem 0x10, dmem 0x20 -> m_addr order is 0x20 then 0x10 then 0x20, alternating; each b_dv goes only to the matching requester.
- Ack stall: m_ack held low for 6 cycles -> m_rd and m_addr stay stable for all 6 cycles; exactly one transfer occurs.
- Withdrawal: b_rd_i dropped in S_WAIT, m_dv arrives -> no b_dv_i pulse; b_rdata_i unchanged; busy returns to 0 one cycle after S_RESP.
- Reset mid-transaction: rst_n low during S_WAIT -> outputs zero asynchronously the same cycle; a late m_dv after release produces no b_dv.
- Held request after completion: b_rd_d still 1 in the cycle after b_dv_d -> no second m_rd for dmem unless the request persists past the mask cycle.
